// File: rtl/instr_dispatch.sv
// Instruction dispatcher: fetches one word, decodes it and hands it to the ALU or move sequencer.
// Optional run-phase watchdog enabled with `define DISPATCH_TIMEOUT_EN (budget TIMEOUT_CYCLES).
module instr_dispatch #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        ir_latch,
    output logic        pc_inc,
    output logic        alu_start,
    input  logic        alu_done,
    output logic        mov_start,
    input  logic        mov_done,
    output logic [3:0]  opcode,
    output logic [5:0]  param1,
    output logic [5:0]  param2,
    output logic        busy,
    output logic        halted,
    output logic        error,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {IDLE, DECODE, ALU_RUN, MOV_RUN, HALT, ERR} state_t;

    state_t      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [5:0]  param1_q, param1_d;
    logic [5:0]  param2_q, param2_d;
    logic [15:0] retired_q, retired_d;
    logic        tmo_hit;

    logic is_nop, is_halt, is_alu, is_mov;
    assign is_nop  = (opcode_q == 4'h0);
    assign is_halt = (opcode_q == 4'h8);
    assign is_alu  = opcode_q[3] && !is_halt;
    assign is_mov  = !opcode_q[3] && !is_nop;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // Held at zero outside RUN, so it is already clear on RUN entry.
    always_comb begin
        tmo_d = '0;
        if (state_q == ALU_RUN || state_q == MOV_RUN)
            tmo_d = tmo_q + 1'b1;
    end

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        param1_d    = param1_q;
        param2_d    = param2_q;
        retired_d   = retired_q;
        instr_ready = 1'b0;
        ir_latch    = 1'b0;
        pc_inc      = 1'b0;
        alu_start   = 1'b0;
        mov_start   = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        error       = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && !rst) begin
                    ir_latch = 1'b1;
                    opcode_d = instr[15:12];
                    param1_d = instr[11:6];
                    param2_d = instr[5:0];
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                busy      = 1'b1;
                pc_inc    = 1'b1;
                alu_start = is_alu;
                mov_start = is_mov;
                if (is_nop) begin
                    state_d   = IDLE;
                    retired_d = retired_q + 16'd1;
                end else if (is_halt) state_d = HALT;
                else if (is_alu)      state_d = ALU_RUN;
                else                  state_d = MOV_RUN;
            end
            // Done on the expiry cycle still retires: it is tested before the timeout.
            ALU_RUN: begin
                busy = 1'b1;
                if (alu_done) begin
                    state_d   = IDLE;
                    retired_d = retired_q + 16'd1;
                end else if (tmo_hit) state_d = ERR;
            end
            MOV_RUN: begin
                busy = 1'b1;
                if (mov_done) begin
                    state_d   = IDLE;
                    retired_d = retired_q + 16'd1;
                end else if (tmo_hit) state_d = ERR;
            end
            HALT: halted = 1'b1;
`ifdef DISPATCH_TIMEOUT_EN
            ERR:  error = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            param1_q  <= '0;
            param2_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            param1_q  <= param1_d;
            param2_q  <= param2_d;
            retired_q <= retired_d;
        end
    end

    assign opcode  = opcode_q;
    assign param1  = param1_q;
    assign param2  = param2_q;
    assign retired = retired_q;

endmodule
